// File: rtl/spi_master.sv
// spi_master
// Command-driven SPI master (mode 0) producing 64-bit frames:
// 8-bit command, 24-bit address, 32-bit data phase, all MSB first.
// A read command (READ_CMD) captures 32 MISO bits from the data phase into rdata.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    frame request, sampled only while idle
//   cmd      command byte, latched on accepted start
//   address  24-bit slave address, latched on accepted start
//   wdata    32-bit data-phase MOSI word, latched on accepted start
//   miso     serial data from slave
//   sclk     SPI clock, idle low
//   cs       active-low chip select
//   mosi     serial data to slave
//   busy     frame in progress
//   done     one-cycle pulse at frame end
//   rdata    last read-frame capture
module spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [7:0]  READ_CMD = 8'h56
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [23:0] address,
    input  logic [31:0] wdata,
    input  logic        miso,
    output logic        sclk,
    output logic        cs,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;

    localparam logic [8:0] HALF_LAST  = 9'(CLK_DIV - 1);
    // TRAIL spans the final SCLK low half-period plus the CS hold time.
    localparam logic [8:0] TRAIL_LAST = 9'(2 * CLK_DIV - 1);

    logic [1:0]  state;
    logic [8:0]  cnt;
    logic [5:0]  bit_idx;
    logic        is_read;
    logic [63:0] shift_reg;
    logic [31:0] rx_reg;

    logic accept;
    logic half_tick;
    logic rise_ev;
    logic fall_ev;
    logic shift_ev;
    logic capture;

    always_comb begin
        accept    = (state == S_IDLE) && start;
        half_tick = (cnt == HALF_LAST);
        rise_ev   = half_tick && ((state == S_LEAD) || ((state == S_SHIFT) && !sclk));
        fall_ev   = half_tick && (state == S_SHIFT) && sclk;
        shift_ev  = fall_ev && (bit_idx != 6'd63);
        // Data phase is bit index 32..63, i.e. bit_idx[5] set.
        capture   = rise_ev && is_read && bit_idx[5];
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            is_read <= 1'b0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    sclk    <= 1'b0;
                    if (start) begin
                        state   <= S_LEAD;
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        mosi    <= cmd[7];
                        is_read <= (cmd == READ_CMD);
                    end
                end
                S_LEAD: begin
                    if (half_tick) begin
                        cnt   <= '0;
                        sclk  <= 1'b1;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                S_SHIFT: begin
                    if (half_tick) begin
                        cnt  <= '0;
                        sclk <= ~sclk;
                        if (sclk) begin
                            if (bit_idx == 6'd63) begin
                                state <= S_TRAIL;
                            end else begin
                                bit_idx <= bit_idx + 6'd1;
                                mosi    <= shift_reg[62];
                            end
                        end
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                default: begin
                    if (cnt == TRAIL_LAST) begin
                        cnt   <= '0;
                        cs    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                        if (is_read) begin
                            rdata <= rx_reg;
                        end
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
            endcase
        end
    end

    // Shift datapath; contents are only meaningful after an accepted start
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_reg <= {cmd, address, wdata};
        end else if (shift_ev) begin
            shift_reg <= {shift_reg[62:0], 1'b0};
        end
        if (capture) begin
            rx_reg <= {rx_reg[30:0], miso};
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master
// Directed bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=1) share
// stimulus; sel chooses which one is driven and observed.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        sel;
    logic        miso;
    logic [7:0]  cmd;
    logic [23:0] address;
    logic [31:0] wdata;

    logic        start4, sclk4, cs4, mosi4, busy4, done4;
    logic        start1, sclk1, cs1, mosi1, busy1, done1;
    logic [31:0] rdata4, rdata1;

    assign start4 = start & ~sel;
    assign start1 = start & sel;

    logic        sclk_o, cs_o, mosi_o, busy_o, done_o;
    logic [31:0] rdata_o;
    assign sclk_o  = sel ? sclk1  : sclk4;
    assign cs_o    = sel ? cs1    : cs4;
    assign mosi_o  = sel ? mosi1  : mosi4;
    assign busy_o  = sel ? busy1  : busy4;
    assign done_o  = sel ? done1  : done4;
    assign rdata_o = sel ? rdata1 : rdata4;

    spi_master #(.CLK_DIV(4), .READ_CMD(8'h56)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .cmd(cmd), .address(address),
        .wdata(wdata), .miso(miso), .sclk(sclk4), .cs(cs4), .mosi(mosi4),
        .busy(busy4), .done(done4), .rdata(rdata4)
    );

    spi_master #(.CLK_DIV(1), .READ_CMD(8'h56)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cmd(cmd), .address(address),
        .wdata(wdata), .miso(miso), .sclk(sclk1), .cs(cs1), .mosi(mosi1),
        .busy(busy1), .done(done1), .rdata(rdata1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Per-frame observations
    logic [63:0] r_bits;
    int          r_rises;
    int          r_cs_low;
    int          r_dones;
    int          r_first;
    int          r_done_cyc;
    logic [31:0] r_rdata;
    logic        r_cs_at_done;

    // Sample s is taken at the negedge following the s-th clock edge after acceptance
    // (acceptance edge counts as the first), so cs falls at sample 1.
    task automatic run_frame(input logic [7:0] c, input logic [23:0] a, input logic [31:0] w,
                             input logic [31:0] mpat, input int d, input bit pre,
                             input int poke1, input int poke2, input int abort_rise,
                             input bit chain, input logic [7:0] nc, input logic [23:0] na,
                             input logic [31:0] nw);
        logic prev;
        r_bits = '0; r_rises = 0; r_cs_low = 0; r_dones = 0;
        r_first = -1; r_done_cyc = -1; r_rdata = '0; r_cs_at_done = 1'b0;
        if (!pre) begin
            @(negedge clk);
            cmd = c; address = a; wdata = w; start = 1'b1;
        end
        @(negedge clk);
        prev = 1'b0;
        for (int s = 1; s <= 130 * d + 10; s++) begin
            if (s > 1) @(negedge clk);
            start = (s == poke1) || (s == poke2);
            if (s == 1) begin
                cmd = ~c; address = ~a; wdata = ~w;
            end
            if (sclk_o && !prev) begin
                if (r_rises < 64) r_bits[63 - r_rises] = mosi_o;
                if (r_rises == 0) r_first = s;
                r_rises++;
                if (r_rises == abort_rise) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_cs",    64'(cs_o),   64'd1);
                    chk("abort_sclk",  64'(sclk_o), 64'd0);
                    chk("abort_busy",  64'(busy_o), 64'd0);
                    chk("abort_done",  64'(done_o), 64'd0);
                    chk("abort_rdata", 64'(rdata_o), 64'd0);
                end
            end
            if (!sclk_o && prev && r_rises >= 32 && r_rises < 64) miso = mpat[63 - r_rises];
            prev = sclk_o;
            if (!cs_o) r_cs_low++;
            if (done_o) begin
                r_dones++;
                r_done_cyc = s;
                r_rdata = rdata_o;
                r_cs_at_done = cs_o;
                if (chain) begin
                    cmd = nc; address = na; wdata = nw; start = 1'b1;
                    break;
                end
            end
        end
        if (!chain) start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; miso = 1'b0;
        cmd = '0; address = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs",    64'(cs4),    64'd1);
        chk("rst_sclk",  64'(sclk4),  64'd0);
        chk("rst_mosi",  64'(mosi4),  64'd0);
        chk("rst_busy",  64'(busy4),  64'd0);
        chk("rst_done",  64'(done4),  64'd0);
        chk("rst_rdata", 64'(rdata4), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write frame
        run_frame(8'h55, 24'h123456, 32'hDEADBEEF, 32'h0, 4, 1'b0, -1, -1, -1, 1'b0, 8'h0, 24'h0, 32'h0);
        chk("wr_bits",   r_bits, 64'h55123456DEADBEEF);
        chk("wr_rises",  64'(r_rises), 64'd64);
        chk("wr_first",  64'(r_first), 64'd5);
        chk("wr_donecyc", 64'(r_done_cyc), 64'd521);
        chk("wr_cslow",  64'(r_cs_low), 64'd520);
        chk("wr_dones",  64'(r_dones), 64'd1);
        chk("wr_rdata",  64'(r_rdata), 64'd0);

        // Read frame with 0x88888888 on MISO
        run_frame(8'h56, 24'h000010, 32'h0BADF00D, 32'h88888888, 4, 1'b0, -1, -1, -1, 1'b0, 8'h0, 24'h0, 32'h0);
        chk("rd1_bits",  r_bits, 64'h560000100BADF00D);
        chk("rd1_rdata", 64'(r_rdata), 64'h88888888);
        chk("rd1_dones", 64'(r_dones), 64'd1);

        // Read, then a write started in the done cycle
        run_frame(8'h56, 24'h0000A0, 32'h13579BDF, 32'hA5C30F01, 4, 1'b0, -1, -1, -1, 1'b1,
                  8'h55, 24'h654321, 32'hCAFEF00D);
        chk("rd2_rdata",   64'(r_rdata), 64'hA5C30F01);
        chk("rd2_cs_done", 64'(r_cs_at_done), 64'd1);
        run_frame(8'h55, 24'h654321, 32'hCAFEF00D, 32'h0, 4, 1'b1, -1, -1, -1, 1'b0, 8'h0, 24'h0, 32'h0);
        chk("b2b_bits",  r_bits, 64'h55654321CAFEF00D);
        chk("b2b_cslow", 64'(r_cs_low), 64'd520);
        chk("b2b_first", 64'(r_first), 64'd5);
        chk("b2b_dones", 64'(r_dones), 64'd1);
        chk("b2b_rdata", 64'(r_rdata), 64'hA5C30F01);

        // start pulses while busy are ignored
        run_frame(8'h55, 24'h0F0F0F, 32'h01234567, 32'h0, 4, 1'b0, 50, 300, -1, 1'b0, 8'h0, 24'h0, 32'h0);
        chk("poke_bits",  r_bits, 64'h550F0F0F01234567);
        chk("poke_rises", 64'(r_rises), 64'd64);
        chk("poke_cslow", 64'(r_cs_low), 64'd520);
        chk("poke_dones", 64'(r_dones), 64'd1);

        // Reset at the 20th sclk rise of a read frame
        run_frame(8'h56, 24'h000020, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 1'b0, -1, -1, 20, 1'b0, 8'h0, 24'h0, 32'h0);
        chk("abort_rises", 64'(r_rises), 64'd20);
        chk("abort_dones", 64'(r_dones), 64'd0);
        chk("abort_rd_after", 64'(rdata4), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CLK_DIV=1 frame after reset release
        sel = 1'b1;
        run_frame(8'h55, 24'hABCDEF, 32'h12345678, 32'h0, 1, 1'b0, -1, -1, -1, 1'b0, 8'h0, 24'h0, 32'h0);
        chk("d1_bits",    r_bits, 64'h55ABCDEF12345678);
        chk("d1_rises",   64'(r_rises), 64'd64);
        chk("d1_first",   64'(r_first), 64'd2);
        chk("d1_donecyc", 64'(r_done_cyc), 64'd131);
        chk("d1_cslow",   64'(r_cs_low), 64'd130);
        chk("d1_dones",   64'(r_dones), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
